// File: rtl/clk_div_gen_pkg.sv
// clk_div_pkg: shared definitions for the clk_div_gen divider slice.
//   DEFAULT_HALF_C : reset half-period (2 gives divide-by-4)
//   MAX_CH         : largest supported channel count
//   chan_state_e   : per-channel FSM state
//   ch_width()     : width of a channel index, minimum 1
package clk_div_pkg;

  localparam int unsigned DEFAULT_HALF_C = 2;
  localparam int unsigned MAX_CH         = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    RUN_PEND = 2'd2
  } chan_state_e;

  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_gen_if.sv
// clk_div_gen_if: valid/ready configuration port of clk_div_gen.
//   cfg_valid : request, cfg_ready : accept
//   cfg_ch    : target channel (CH_W bits, must match clk_div_pkg::ch_width(NUM_CH))
//   cfg_half  : new half-period in clk cycles (CNT_W bits)
// master drives requests, slave (the divider) returns cfg_ready.
interface clk_div_gen_if #(
  parameter int unsigned CH_W  = 1,
  parameter int unsigned CNT_W = 8
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_half;

  modport master (output cfg_valid, output cfg_ch, output cfg_half, input  cfg_ready);
  modport slave  (input  cfg_valid, input  cfg_ch, input  cfg_half, output cfg_ready);

endinterface

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel.
//   clk, reset  : system clock, synchronous active-high reset
//   ch_en       : run enable
//   load        : accepted config write for this channel
//   load_half   : half-period carried by that write
//   align       : phase restart (only with CLK_DIV_PHASE_ALIGN_EN defined)
//   clk_out     : registered 50%-duty divided clock
//   rise_en     : 1-cycle strobe in the cycle clk_out first reads 1
//   fall_en     : 1-cycle strobe in the cycle clk_out first reads 0
//   pending     : shadow half-period loaded but not yet active
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_C
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ch_en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_half,
`ifdef CLK_DIV_PHASE_ALIGN_EN
  input  logic             align,
`endif
  output logic             clk_out,
  output logic             rise_en,
  output logic             fall_en,
  output logic             pending
);

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] shd_q, shd_d;
  logic             clk_d, rise_d, fall_d, pend_d;
  logic [CNT_W-1:0] h_m1;
  logic             last;
  logic             force_low;

  // half == 0 behaves as half == 1, so the terminal count is 0 in both cases
  assign h_m1 = (act_q == '0) ? '0 : act_q - 1'b1;

`ifdef CLK_DIV_PHASE_ALIGN_EN
  assign force_low = ~ch_en | align;
`else
  assign force_low = ~ch_en;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clk_d   = clk_out;
    act_d   = act_q;
    shd_d   = shd_q;
    pend_d  = pending;
    last    = (cnt_q == h_m1);

    if (load) begin
      shd_d  = load_half;
      pend_d = 1'b1;
    end

    if (force_low) begin
      // disabled or aligned: restart the period from zero, and a waiting
      // shadow needs no boundary so it is taken immediately
      cnt_d = '0;
      clk_d = 1'b0;
      if (pending) begin
        act_d  = shd_q;
        pend_d = 1'b0;
      end
    end else begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
      clk_d = last ? ~clk_out : clk_out;
      unique case (state_q)
        RUN_PEND: begin
          // swap ratio only at the end of a full period (1-to-0 toggle)
          if (last && clk_out) begin
            act_d  = shd_q;
            pend_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    if (!ch_en)      state_d = IDLE;
    else if (pend_d) state_d = RUN_PEND;
    else             state_d = RUN;

    rise_d = clk_d & ~clk_out;
    fall_d = ~clk_d & clk_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      clk_out <= 1'b0;
      rise_en <= 1'b0;
      fall_en <= 1'b0;
      act_q   <= CNT_W'(DEFAULT_HALF);
      shd_q   <= CNT_W'(DEFAULT_HALF);
      pending <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clk_out <= clk_d;
      rise_en <= rise_d;
      fall_en <= fall_d;
      act_q   <= act_d;
      shd_q   <= shd_d;
      pending <= pend_d;
    end
  end

endmodule

// File: rtl/clk_div_gen.sv
// clk_div_gen: multi-channel programmable 50%-duty clock divider.
//   clk, reset : system clock, synchronous active-high reset
//   ch_en      : per-channel run enable
//   cfg        : clk_div_gen_if.slave config port (valid/ready, channel, half)
//   align      : phase restart of all enabled channels, present only when
//                CLK_DIV_PHASE_ALIGN_EN is defined
//   clk_out    : divided clocks
//   rise_en    : per-channel rise strobes
//   fall_en    : per-channel fall strobes
//   pending    : per-channel shadow-loaded flags
// cfg_ch values >= NUM_CH are accepted and dropped.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_C
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  clk_div_gen_if.slave      cfg,
`ifdef CLK_DIV_PHASE_ALIGN_EN
  input  logic              align,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] rise_en,
  output logic [NUM_CH-1:0] fall_en,
  output logic [NUM_CH-1:0] pending
);

  localparam int unsigned CH_W   = ch_width(NUM_CH);
  localparam int unsigned SLOT_N = 1 << CH_W;

  // one ready bit per encodable channel index; unused slots always accept
  logic [SLOT_N-1:0] ready_vec;

  for (genvar g = 0; g < SLOT_N; g++) begin : g_rdy
    if (g < NUM_CH) begin : g_used
      assign ready_vec[g] = ~pending[g];
    end else begin : g_unused
      assign ready_vec[g] = 1'b1;
    end
  end

  assign cfg.cfg_ready = ready_vec[cfg.cfg_ch];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic load;
    assign load = cfg.cfg_valid & ready_vec[g] & (cfg.cfg_ch == CH_W'(g));

    clk_div_chan #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .ch_en     (ch_en[g]),
      .load      (load),
      .load_half (cfg.cfg_half),
`ifdef CLK_DIV_PHASE_ALIGN_EN
      .align     (align),
`endif
      .clk_out   (clk_out[g]),
      .rise_en   (rise_en[g]),
      .fall_en   (fall_en[g]),
      .pending   (pending[g])
    );
  end

endmodule
